lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store unit directly downstream of the ALU: takes the ALU result as the effective byte address plus rs2 store data.
//  Runs the RV32I LB/LH/LW/LBU/LHU/SB/SH/SW access on a req/gnt/rvalid data-memory port.
//  Stalls the core while a transfer is outstanding, then returns load data aligned and extended for register writeback.
// PARAMETERS
//  ADDR_W   32  width of effective address and memory address
//  DATA_W   32  data width; fixed at 32 for RV32I, other values unsupported
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_rst_n        in   1   reset, asynchronous, active-low
//  i_lsu_req      in   1   core requests an access; held high until o_lsu_done
//  i_lsu_wren     in   1   1 = store, 0 = load
//  i_funct3       in   3   RV32I funct3 (size / signedness)
//  i_addr         in   32  effective byte address (ALU o_alu_res)
//  i_st_data      in   32  store data (rs2)
//  o_ld_data      out  32  extended load result, valid while o_lsu_done=1
//  o_lsu_done     out  1   one-cycle completion pulse
//  o_lsu_stall    out  1   core must hold PC/pipeline
//  o_lsu_err      out  1   misaligned or illegal funct3; no access issued
//  o_mem_req      out  1   memory request
//  o_mem_we       out  1   memory write enable
//  o_mem_addr     out  32  word-aligned byte address ([1:0]=0)
//  o_mem_wdata    out  32  lane-replicated store data
//  o_mem_bmask    out  4   byte-lane write mask
//  i_mem_gnt      in   1   memory accepts the request this cycle
//  i_mem_rvalid   in   1   read data valid
//  i_mem_rdata    in   32  read word
// BEHAVIOUR
//  FSM states: IDLE, REQ, RESP, DONE. Reset -> IDLE; every output 0, captured regs 0.
//  IDLE: i_lsu_req=1 and the access is legal -> capture op/addr/data, go to REQ.
//    Same cycle, o_lsu_stall=1 (combinational).
//  IDLE: i_lsu_req=1 and the access is illegal -> o_lsu_err=1 (combinational), o_lsu_stall=0, no memory request, stay IDLE.
//    Illegal = LH/LHU/SH with addr[0]!=0; LW/SW with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3>010.
//  REQ: o_mem_req=1. o_mem_we/addr/wdata/bmask come from the captured regs and stay stable until i_mem_gnt.
//    On gnt: store -> DONE; load -> RESP.
//  RESP: o_mem_req=0. On i_mem_rvalid: register the extended data into o_ld_data, go to DONE.
//    i_mem_rvalid in the same cycle as gnt is ignored; the response must come at least 1 cycle after gnt.
//  DONE: o_lsu_done=1, o_lsu_stall=0. Go to IDLE unconditionally.
//    i_lsu_req is not sampled in DONE, so a held request is never re-accepted.
//  o_lsu_stall = (IDLE & req & legal) | REQ | RESP.
//  Minimum latency with gnt immediate and rvalid next cycle: store accept->done 2 cycles; load 3 cycles.
//  Store lanes, with off=addr[1:0]:
//    SB: wdata={4{d[7:0]}},  bmask=4'b0001<<off
//    SH: wdata={2{d[15:0]}}, bmask=4'b0011<<off
//    SW: wdata=d,            bmask=4'b1111
//    Loads drive bmask=4'b0000, we=0.
//  Load extract: select byte/half at off from rdata.
//    LB/LH sign-extend to 32; LBU/LHU zero-extend; LW passes through.
//  o_ld_data holds its value outside DONE and is updated only on rvalid in RESP.
//  Async reset in any state -> IDLE immediately, o_mem_req drops the same instant, outstanding response discarded.
//  An i_mem_rvalid arriving in IDLE/REQ/DONE is ignored.
// STRUCTURE
//  singlecycle_pkg gains:
//    LSUState_e {IDLE,REQ,RESP,DONE}
//    funct3 constants F3_LB..F3_SW, F3_LBU, F3_LHU
//  Sub-module lsu_align (combinational): store lane replication + bmask, load byte/half select + extension,
//    legality check. FSM and capture regs stay in lsu.
// TESTING
//  SW a=0x100 d=0xDEADBEEF, gnt at first REQ cycle -> mem_addr=0x100, bmask=1111, wdata=DEADBEEF, done 2 cycles after accept.
//  SB a=0x103 d=0x000000A5 -> bmask=1000, wdata=A5A5A5A5, we=1.
//  LB a=0x102 rdata=0x1280FF00 -> o_ld_data=0xFFFFFF80 on done; LBU same -> 0x00000080; LHU a=0x102 -> 0x00001280.
//  LH a=0x101 -> o_lsu_err=1 same cycle, o_mem_req never asserts, o_lsu_stall=0.
//  LW, gnt delayed 3 cycles, rvalid 2 cycles after gnt -> mem_* stable during wait, stall high throughout, one done pulse.
//  Reset asserted in RESP -> outputs 0 at once, late rvalid ignored; subsequent SW completes normally.

Source files
------------

// File: rtl/singlecycle_pkg.sv
// Shared definitions for the single-cycle core: load/store unit state
// encoding and the RV32I funct3 codes for loads and stores.
package singlecycle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } LSUState_e;

    // Loads
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    // Stores
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath of the load/store unit.
//   i_funct3/i_wren/i_off : incoming access, used for legality and store lanes
//   i_st_data             : rs2 store data
//   o_legal               : access is aligned and funct3 is defined
//   o_wdata/o_bmask       : lane-replicated store data and byte mask (0 mask for loads)
//   i_ld_funct3/i_ld_off  : captured load op, used to pick bytes out of i_rdata
//   i_rdata/o_ld_data     : memory word in, extended register value out
module lsu_align
    import singlecycle_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        i_funct3,
    input  logic              i_wren,
    input  logic [1:0]        i_off,
    input  logic [DATA_W-1:0] i_st_data,
    output logic              o_legal,
    output logic [DATA_W-1:0] o_wdata,
    output logic [3:0]        o_bmask,
    input  logic [2:0]        i_ld_funct3,
    input  logic [1:0]        i_ld_off,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_ld_data
);

    logic [DATA_W-1:0] rsh;

    // Legality: halfwords need even addresses, words need 4-byte alignment.
    always_comb begin
        o_legal = 1'b0;
        if (i_wren) begin
            unique case (i_funct3)
                F3_SB:   o_legal = 1'b1;
                F3_SH:   o_legal = ~i_off[0];
                F3_SW:   o_legal = (i_off == 2'b00);
                default: o_legal = 1'b0;
            endcase
        end else begin
            unique case (i_funct3)
                F3_LB, F3_LBU: o_legal = 1'b1;
                F3_LH, F3_LHU: o_legal = ~i_off[0];
                F3_LW:         o_legal = (i_off == 2'b00);
                default:       o_legal = 1'b0;
            endcase
        end
    end

    // Store lanes: data is replicated so the mask alone selects the bytes.
    always_comb begin
        o_wdata = i_st_data;
        o_bmask = 4'b0000;
        if (i_wren) begin
            unique case (i_funct3)
                F3_SB: begin
                    o_wdata = {4{i_st_data[7:0]}};
                    o_bmask = 4'b0001 << i_off;
                end
                F3_SH: begin
                    o_wdata = {2{i_st_data[15:0]}};
                    o_bmask = 4'b0011 << i_off;
                end
                default: begin
                    o_wdata = i_st_data;
                    o_bmask = 4'b1111;
                end
            endcase
        end
    end

    // Load extract: shift the addressed byte/half down to bit 0, then extend.
    assign rsh = i_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        unique case (i_ld_funct3)
            F3_LB:   o_ld_data = {{24{rsh[7]}}, rsh[7:0]};
            F3_LH:   o_ld_data = {{16{rsh[15]}}, rsh[15:0]};
            F3_LBU:  o_ld_data = {24'd0, rsh[7:0]};
            F3_LHU:  o_ld_data = {16'd0, rsh[15:0]};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns an ALU effective address plus rs2 into one RV32I
// access on a req/gnt/rvalid data-memory port and stalls the core until done.
//   i_lsu_req/i_lsu_wren/i_funct3/i_addr/i_st_data : core access request
//   o_ld_data/o_lsu_done/o_lsu_stall/o_lsu_err      : core result and control
//   o_mem_* / i_mem_gnt/i_mem_rvalid/i_mem_rdata    : data-memory port
module lsu
    import singlecycle_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lsu_req,
    input  logic              i_lsu_wren,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_st_data,
    output logic [DATA_W-1:0] o_ld_data,
    output logic              o_lsu_done,
    output logic              o_lsu_stall,
    output logic              o_lsu_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    LSUState_e         state_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        bmask_q;
    logic [DATA_W-1:0] ld_q;
    logic              req_q;
    logic              done_q;

    logic              legal;
    logic [DATA_W-1:0] wdata_d;
    logic [3:0]        bmask_d;
    logic [DATA_W-1:0] ld_d;
    logic              accept;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .i_funct3    (i_funct3),
        .i_wren      (i_lsu_wren),
        .i_off       (i_addr[1:0]),
        .i_st_data   (i_st_data),
        .o_legal     (legal),
        .o_wdata     (wdata_d),
        .o_bmask     (bmask_d),
        .i_ld_funct3 (f3_q),
        .i_ld_off    (off_q),
        .i_rdata     (i_mem_rdata),
        .o_ld_data   (ld_d)
    );

    assign accept = (state_q == IDLE) && i_lsu_req && legal;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            bmask_q <= 4'd0;
            ld_q    <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        we_q    <= i_lsu_wren;
                        f3_q    <= i_funct3;
                        off_q   <= i_addr[1:0];
                        addr_q  <= {i_addr[ADDR_W-1:2], 2'b00};
                        wdata_q <= wdata_d;
                        bmask_q <= bmask_d;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (i_mem_gnt) begin
                        req_q <= 1'b0;
                        if (we_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (i_mem_rvalid) begin
                        ld_q    <= ld_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    // DONE: request input deliberately not looked at here.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_lsu_stall = accept || (state_q == REQ) || (state_q == RESP);
    assign o_lsu_err   = (state_q == IDLE) && i_lsu_req && !legal;
    assign o_lsu_done  = done_q;
    assign o_ld_data   = ld_q;
    assign o_mem_req   = req_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_bmask = bmask_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_req = 1'b0, lsu_wren = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = '0, st_data = '0;
    logic [31:0] ld_data;
    logic        done, stall, err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int          n_chk = 0, n_pass = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_ld = '0;

    always #5 clk = ~clk;

    lsu dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_lsu_req(lsu_req), .i_lsu_wren(lsu_wren), .i_funct3(funct3),
        .i_addr(addr), .i_st_data(st_data),
        .o_ld_data(ld_data), .o_lsu_done(done), .o_lsu_stall(stall), .o_lsu_err(err),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
        .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_chk++;
        if ({ld_data, done, stall, err, mem_req, mem_we, mem_addr, mem_wdata, mem_bmask} !== '0)
            $display("FAIL reset_outputs: ld=%h done=%b stall=%b err=%b req=%b we=%b addr=%h wd=%h bm=%b, required all 0",
                     ld_data, done, stall, err, mem_req, mem_we, mem_addr, mem_wdata, mem_bmask);
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One complete access. gdly = REQ cycles without gnt, rdly = cycles from
    // gnt to rvalid (>=1). early_rv pulses a junk rvalid together with gnt.
    task automatic access(input string nm, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input int gdly, input int rdly, input logic early_rv,
                          input logic [31:0] rd, input logic [3:0] exp_bm,
                          input logic [31:0] exp_wd, input logic [31:0] exp_ld);
        logic [31:0] e;
        exp_q.push_back(wr ? last_ld : exp_ld);
        lsu_req = 1'b1; lsu_wren = wr; funct3 = f3; addr = a; st_data = d;
        @(negedge clk);
        n_chk++;
        if ({stall, err, mem_req} !== 3'b100)
            $display("FAIL %s_accept: stall/err/req=%b required 100", nm, {stall, err, mem_req});
        else n_pass++;
        @(posedge clk); #1;
        for (int k = 0; k <= gdly; k++) begin
            if (k == gdly) begin
                mem_gnt = 1'b1;
                if (early_rv) begin mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0; end
            end
            @(negedge clk);
            n_chk++;
            if ({mem_req, mem_we, stall, done} !== {1'b1, wr, 2'b10})
                $display("FAIL %s_req%0d: req/we/stall/done=%b required %b", nm, k,
                         {mem_req, mem_we, stall, done}, {1'b1, wr, 2'b10});
            else n_pass++;
            n_chk++;
            if (mem_addr !== {a[31:2], 2'b00} || mem_bmask !== exp_bm)
                $display("FAIL %s_addr%0d: addr=%h bmask=%b required %h %b", nm, k,
                         mem_addr, mem_bmask, {a[31:2], 2'b00}, exp_bm);
            else n_pass++;
            if (wr) begin
                n_chk++;
                if (mem_wdata !== exp_wd)
                    $display("FAIL %s_wdata%0d: wdata=%h required %h", nm, k, mem_wdata, exp_wd);
                else n_pass++;
            end
            @(posedge clk); #1 mem_gnt = 1'b0; mem_rvalid = 1'b0;
        end
        if (!wr) begin
            for (int k = 1; k <= rdly; k++) begin
                if (k == rdly) begin mem_rvalid = 1'b1; mem_rdata = rd; end
                @(negedge clk);
                n_chk++;
                if ({mem_req, stall, done} !== 3'b010 || ld_data !== last_ld)
                    $display("FAIL %s_resp%0d: req/stall/done=%b ld=%h required 010 %h", nm, k,
                             {mem_req, stall, done}, ld_data, last_ld);
                else n_pass++;
                @(posedge clk); #1 mem_rvalid = 1'b0;
            end
        end
        lsu_req = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({done, stall, mem_req} !== 3'b100)
            $display("FAIL %s_done: done/stall/req=%b required 100", nm, {done, stall, mem_req});
        else n_pass++;
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s_scoreboard: queue empty at done, required one entry", nm);
        end else begin
            e = exp_q.pop_front();
            if (ld_data !== e)
                $display("FAIL %s_lddata: ld=%h required %h", nm, ld_data, e);
            else n_pass++;
            last_ld = e;
        end
        @(negedge clk);
        n_chk++;
        if ({done, stall} !== 2'b00)
            $display("FAIL %s_single_done: done/stall=%b required 00", nm, {done, stall});
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_stores();
        access("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 1'b0, '0, 4'b1111, 32'hDEADBEEF, '0);
        access("sb", 1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 1, 1'b0, '0, 4'b1000, 32'hA5A5A5A5, '0);
        access("sh", 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 1, 1, 1'b0, '0, 4'b1100, 32'hABCDABCD, '0);
        access("sb0", 1'b1, 3'b000, 32'h201, 32'h0000003C, 0, 1, 1'b0, '0, 4'b0010, 32'h3C3C3C3C, '0);
    endtask

    task automatic test_loads();
        access("lb", 1'b0, 3'b000, 32'h102, '0, 0, 1, 1'b0, 32'h1280FF00, 4'b0000, '0, 32'hFFFFFF80);
        access("lbu", 1'b0, 3'b100, 32'h102, '0, 0, 1, 1'b0, 32'h1280FF00, 4'b0000, '0, 32'h00000080);
        access("lhu", 1'b0, 3'b101, 32'h102, '0, 0, 1, 1'b0, 32'h1280FF00, 4'b0000, '0, 32'h00001280);
        access("lh", 1'b0, 3'b001, 32'h100, '0, 0, 1, 1'b0, 32'h1280FF00, 4'b0000, '0, 32'hFFFFFF00);
        access("lb1", 1'b0, 3'b000, 32'h101, '0, 0, 1, 1'b0, 32'h12807F00, 4'b0000, '0, 32'h0000007F);
    endtask

    task automatic test_lw_delayed();
        access("lw_dly", 1'b0, 3'b010, 32'h104, '0, 3, 2, 1'b1, 32'hCAFEF00D, 4'b0000, '0, 32'hCAFEF00D);
    endtask

    task automatic test_illegal();
        logic [3:0]  wr_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3_t [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] a_t  [4] = '{32'h101, 32'h102, 32'h100, 32'h100};
        for (int i = 0; i < 4; i++) begin
            lsu_req = 1'b1; lsu_wren = wr_t[i][0]; funct3 = f3_t[i]; addr = a_t[i];
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                n_chk++;
                if ({err, stall, mem_req, done} !== 4'b1000)
                    $display("FAIL illegal%0d_c%0d: err/stall/req/done=%b required 1000",
                             i, c, {err, stall, mem_req, done});
                else n_pass++;
                @(posedge clk); #1;
            end
            lsu_req = 1'b0;
            @(negedge clk);
            n_chk++;
            if ({err, mem_req} !== 2'b00)
                $display("FAIL illegal%0d_release: err/req=%b required 00", i, {err, mem_req});
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_resp();
        lsu_req = 1'b1; lsu_wren = 1'b0; funct3 = 3'b010; addr = 32'h108;
        @(posedge clk); #1 mem_gnt = 1'b1;
        @(posedge clk); #1 mem_gnt = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({stall, mem_req} !== 2'b10)
            $display("FAIL rstresp_pre: stall/req=%b required 10", {stall, mem_req});
        else n_pass++;
        rst_n = 1'b0; lsu_req = 1'b0;
        #1;
        n_chk++;
        if ({mem_req, stall, done, err, mem_we} !== 5'b0 || ld_data !== '0 || mem_addr !== '0)
            $display("FAIL rstresp_now: req/stall/done/err/we=%b ld=%h addr=%h required 0",
                     {mem_req, stall, done, err, mem_we}, ld_data, mem_addr);
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
        @(posedge clk); #1 mem_rvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_chk++;
            if ({done, stall, mem_req} !== 3'b000 || ld_data !== '0)
                $display("FAIL rstresp_late%0d: done/stall/req=%b ld=%h required 000 0",
                         c, {done, stall, mem_req}, ld_data);
            else n_pass++;
            @(posedge clk); #1;
        end
        last_ld = '0;
        access("sw_after", 1'b1, 3'b010, 32'h10C, 32'h01234567, 0, 1, 1'b0, '0, 4'b1111, 32'h01234567, '0);
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_lw_delayed();
        test_illegal();
        test_reset_in_resp();
        n_chk++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
